// File: rtl/crossbar_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crossbar_pkg : shared types for the 2x2 crossbar slave arbiters    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package crossbar_pkg;

    typedef enum logic [1:0] {
        NO_REQ = 2'd0,
        WAIT   = 2'd1,
        W_ACK  = 2'd2,
        W_DATA = 2'd3
    } stat_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    // Priority of the status cases: reset, then ownership, then pending request.
    function automatic stat_t stat_f(input logic rst, input state_t state,
                                     input logic is_owner, input logic elig);
        if (rst)                                  return NO_REQ;
        else if (state == ST_RDATA && is_owner)   return W_DATA;
        else if (state == ST_BUSY && is_owner)    return W_ACK;
        else if (elig)                            return WAIT;
        else                                      return NO_REQ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slave_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_arbiter_if : master-side and slave-side signals of one port  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface slave_arbiter_if;
    import crossbar_pkg::*;

    logic        m0_req,   m1_req;
    logic [31:0] m0_addr,  m1_addr;
    logic        m0_cmd,   m1_cmd;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack,   m1_ack;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_cmd;
    logic [31:0] s_wdata;
    logic        s_ack;
    logic        owner;
    stat_t       stat0,    stat1;

    // Environment side: masters and the slave model
    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_cmd, m1_cmd,
               m0_wdata, m1_wdata, s_ack,
        input  m0_ack, m1_ack, s_req, s_addr, s_cmd, s_wdata, owner,
               stat0, stat1
    );

    // Arbiter side
    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_cmd, m1_cmd,
               m0_wdata, m1_wdata, s_ack,
        output m0_ack, m1_ack, s_req, s_addr, s_cmd, s_wdata, owner,
               stat0, stat1
    );
endinterface
`default_nettype wire

// File: rtl/slave_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin grant, purely combinational          |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module rr_arb2 (
    input  logic elig0,
    input  logic elig1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);
    assign gnt_valid = elig0 | elig1;
    // On a tie the master that did not win last time goes next.
    assign gnt_idx   = (elig0 & elig1) ? ~last_grant : elig1;
endmodule
`default_nettype wire

// File: rtl/slave_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_arbiter : per-slave round-robin arbiter and sequencer        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module slave_arbiter
    import crossbar_pkg::*;
#(
    parameter int S_NO = 0
) (
    input  logic           clk,
    input  logic           rst,
    slave_arbiter_if.slave bus
);
    localparam logic C_SEL = S_NO[0];

    state_t      r_state, w_next;
    logic        r_s_req, r_s_cmd, r_owner, r_last_grant;
    logic [31:0] r_s_addr, r_s_wdata;
    logic        w_elig0, w_elig1, w_gnt_valid, w_gnt_idx;

    assign w_elig0 = bus.m0_req & (bus.m0_addr[31] == C_SEL);
    assign w_elig1 = bus.m1_req & (bus.m1_addr[31] == C_SEL);

    rr_arb2 u_rr_arb2 (
        .elig0      (w_elig0),
        .elig1      (w_elig1),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_idx    (w_gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s_req      <= 1'b0;
            r_s_addr     <= '0;
            r_s_cmd      <= CMD_READ;
            r_s_wdata    <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner   <= w_gnt_idx;
                        r_s_addr  <= w_gnt_idx ? bus.m1_addr  : bus.m0_addr;
                        r_s_cmd   <= w_gnt_idx ? bus.m1_cmd   : bus.m0_cmd;
                        r_s_wdata <= w_gnt_idx ? bus.m1_wdata : bus.m0_wdata;
                        r_s_req   <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (bus.s_ack) begin
                        r_last_grant <= r_owner;
                        r_s_req      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_gnt_valid) w_next = ST_BUSY;
            ST_BUSY:  if (bus.s_ack) w_next = (r_s_cmd == CMD_READ) ? ST_RDATA : ST_IDLE;
            ST_RDATA: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Ack is a zero-latency pass-through, only ever to the current owner.
    assign bus.m0_ack  = (r_state == ST_BUSY) & bus.s_ack & ~r_owner;
    assign bus.m1_ack  = (r_state == ST_BUSY) & bus.s_ack &  r_owner;

    assign bus.s_req   = r_s_req;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_cmd   = r_s_cmd;
    assign bus.s_wdata = r_s_wdata;
    assign bus.owner   = r_owner;
    assign bus.stat0   = stat_f(rst, r_state, ~r_owner, w_elig0);
    assign bus.stat1   = stat_f(rst, r_state,  r_owner, w_elig1);
endmodule
`default_nettype wire

// File: tb/tb_slave_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_slave_arbiter : directed bench for two slave_arbiter instances  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_slave_arbiter;
    import crossbar_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0,  m1_addr = '0;
    logic        m0_cmd = 1'b0, m1_cmd = 1'b0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        s_ack0 = 1'b0, s_ack1 = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    slave_arbiter_if b0 ();
    slave_arbiter_if b1 ();

    // Both slave ports see the same masters; only the address decides.
    assign b0.m0_req = m0_req;     assign b1.m0_req = m0_req;
    assign b0.m1_req = m1_req;     assign b1.m1_req = m1_req;
    assign b0.m0_addr = m0_addr;   assign b1.m0_addr = m0_addr;
    assign b0.m1_addr = m1_addr;   assign b1.m1_addr = m1_addr;
    assign b0.m0_cmd = m0_cmd;     assign b1.m0_cmd = m0_cmd;
    assign b0.m1_cmd = m1_cmd;     assign b1.m1_cmd = m1_cmd;
    assign b0.m0_wdata = m0_wdata; assign b1.m0_wdata = m0_wdata;
    assign b0.m1_wdata = m1_wdata; assign b1.m1_wdata = m1_wdata;
    assign b0.s_ack = s_ack0;      assign b1.s_ack = s_ack1;

    slave_arbiter #(.S_NO(0)) u_s0 (.clk(clk), .rst(rst), .bus(b0));
    slave_arbiter #(.S_NO(1)) u_s1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic exp_owner;
    logic [31:0] exp_wd;

    initial begin
        // Reset and idle
        tick(); tick();
        chk("rst_s_req",   32'(b0.s_req),   32'd0);
        chk("rst_s_addr",  b0.s_addr,       32'd0);
        chk("rst_s_cmd",   32'(b0.s_cmd),   32'd0);
        chk("rst_s_wdata", b0.s_wdata,      32'd0);
        chk("rst_owner",   32'(b0.owner),   32'd0);
        chk("rst_ack0",    32'(b0.m0_ack),  32'd0);
        chk("rst_ack1",    32'(b0.m1_ack),  32'd0);
        chk("rst_stat0",   32'(b0.stat0),   32'(NO_REQ));
        chk("rst_stat1",   32'(b0.stat1),   32'(NO_REQ));
        rst = 1'b0;
        tick(); tick();
        chk("idle_s_req",  32'(b0.s_req),   32'd0);

        // Single write from m0
        m0_req = 1'b1; m0_addr = 32'h0000_0010; m0_cmd = CMD_WRITE; m0_wdata = 32'hA5A5_A5A5;
        #1 chk("wr_stat0_wait", 32'(b0.stat0), 32'(WAIT));
        tick();
        chk("wr_s_req",   32'(b0.s_req),  32'd1);
        chk("wr_s_addr",  b0.s_addr,      32'h0000_0010);
        chk("wr_s_cmd",   32'(b0.s_cmd),  32'd1);
        chk("wr_s_wdata", b0.s_wdata,     32'hA5A5_A5A5);
        chk("wr_owner",   32'(b0.owner),  32'd0);
        chk("wr_stat0",   32'(b0.stat0),  32'(W_ACK));
        tick();
        chk("wr_hold_s_req", 32'(b0.s_req), 32'd1);
        s_ack0 = 1'b1;
        #1 chk("wr_m0_ack", 32'(b0.m0_ack), 32'd1);
        chk("wr_m1_ack",    32'(b0.m1_ack), 32'd0);
        tick();
        chk("wr_s_req_drop",  32'(b0.s_req),  32'd0);
        chk("wr_ack_ignored", 32'(b0.m0_ack), 32'd0);
        s_ack0 = 1'b0; m0_req = 1'b0;
        #1 chk("wr_stat0_done", 32'(b0.stat0), 32'(NO_REQ));

        // Read from m1
        m1_req = 1'b1; m1_addr = 32'h0000_0004; m1_cmd = CMD_READ;
        #1 chk("rd_stat1_wait", 32'(b0.stat1), 32'(WAIT));
        tick();
        chk("rd_stat1_wack", 32'(b0.stat1), 32'(W_ACK));
        chk("rd_owner",      32'(b0.owner), 32'd1);
        chk("rd_s_addr",     b0.s_addr,     32'h0000_0004);
        chk("rd_s_cmd",      32'(b0.s_cmd), 32'd0);
        tick();
        chk("rd_stat1_wack2", 32'(b0.stat1), 32'(W_ACK));
        s_ack0 = 1'b1;
        #1 chk("rd_m1_ack", 32'(b0.m1_ack), 32'd1);
        chk("rd_m0_ack",    32'(b0.m0_ack), 32'd0);
        tick();
        s_ack0 = 1'b0; m1_req = 1'b0;
        #1 chk("rd_stat1_wdata", 32'(b0.stat1), 32'(W_DATA));
        chk("rd_s_req_drop",     32'(b0.s_req), 32'd0);
        tick();
        chk("rd_stat1_end", 32'(b0.stat1), 32'(NO_REQ));

        // Contention: last grant was m1, so m0 goes first
        m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_cmd = CMD_WRITE; m0_wdata = 32'h1111_1111;
        m1_req = 1'b1; m1_addr = 32'h0000_0200; m1_cmd = CMD_WRITE; m1_wdata = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            exp_owner = i[0];
            exp_wd    = exp_owner ? 32'h2222_2222 : 32'h1111_1111;
            tick();
            chk($sformatf("rr_owner%0d", i), 32'(b0.owner), 32'(exp_owner));
            chk($sformatf("rr_wdata%0d", i), b0.s_wdata, exp_wd);
            chk($sformatf("rr_loser_wait%0d", i),
                32'(exp_owner ? b0.stat0 : b0.stat1), 32'(WAIT));
            s_ack0 = 1'b1;
            #1 chk($sformatf("rr_ack%0d", i),
                   32'(exp_owner ? b0.m1_ack : b0.m0_ack), 32'd1);
            tick();
            s_ack0 = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Address filter: m0 to slave 0, m1 to slave 1 at once
        m0_req = 1'b1; m0_addr = 32'h0000_0000; m0_cmd = CMD_WRITE; m0_wdata = 32'h0000_00AA;
        m1_req = 1'b1; m1_addr = 32'h8000_0000; m1_cmd = CMD_WRITE; m1_wdata = 32'h0000_00BB;
        #1 chk("flt_s1_stat0", 32'(b1.stat0), 32'(NO_REQ));
        chk("flt_s0_stat1",    32'(b0.stat1), 32'(NO_REQ));
        tick();
        chk("flt_s0_owner",  32'(b0.owner), 32'd0);
        chk("flt_s1_owner",  32'(b1.owner), 32'd1);
        chk("flt_s1_s_addr", b1.s_addr,     32'h8000_0000);
        chk("flt_s1_stat0b", 32'(b1.stat0), 32'(NO_REQ));
        s_ack0 = 1'b1; s_ack1 = 1'b1;
        #1 chk("flt_s0_m0_ack", 32'(b0.m0_ack), 32'd1);
        chk("flt_s1_m1_ack",    32'(b1.m1_ack), 32'd1);
        chk("flt_s1_m0_ack",    32'(b1.m0_ack), 32'd0);
        tick();
        s_ack0 = 1'b0; s_ack1 = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Reset mid-BUSY; last grant on slave 0 is m0 right now
        m0_req = 1'b1; m0_addr = 32'h0000_0020; m0_cmd = CMD_WRITE; m0_wdata = 32'h0000_0033;
        tick();
        chk("mr_busy_s_req", 32'(b0.s_req), 32'd1);
        rst = 1'b1;
        #1 chk("mr_stat0_rst", 32'(b0.stat0), 32'(NO_REQ));
        tick();
        chk("mr_s_req", 32'(b0.s_req), 32'd0);
        s_ack0 = 1'b1;
        #1 chk("mr_no_ack", 32'(b0.m0_ack), 32'd0);
        rst = 1'b0; s_ack0 = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h0000_0030; m1_cmd = CMD_WRITE;
        tick();
        chk("mr_tie_owner", 32'(b0.owner), 32'd0);
        s_ack0 = 1'b1;
        tick();
        s_ack0 = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/slave_arbiter.md
# slave_arbiter

Per-slave arbitration and sequencing controller for the 2-master × 2-slave crossbar. Each slave port has one instance. The instance selects one of the two masters that address its slave, using round-robin order. It forwards that master's request, routes the slave's ack back to the granted master, and tracks the read-data cycle. It drives the per-master status codes `stat0`/`stat1` (`NO_REQ`/`WAIT`/`W_ACK`/`W_DATA`) that the read-data router consumes to steer `rdata` to the waiting master.

## Interface
Parameters:
- `S_NO`, default 0: slave number. A master targets this slave when `mX_addr[31] == S_NO`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `m0_req`, `m1_req` in 1: master request. The master holds it, with addr/cmd/wdata, until it sees its ack.
- `m0_addr`, `m1_addr` in 32: master address. Bit 31 selects the slave.
- `m0_cmd`, `m1_cmd` in 1: 0 = read, 1 = write.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_ack`, `m1_ack` out 1: ack to master, combinational.
- `s_req` out 1: request to slave, registered.
- `s_addr` out 32, `s_cmd` out 1, `s_wdata` out 32: registered copies of the granted master's fields.
- `s_ack` in 1: slave ack.
- `owner` out 1: index of the currently granted master.
- `stat0`, `stat1` out 2: per-master status for this slave.

## Operation
Status encoding: `NO_REQ`=0, `WAIT`=1, `W_ACK`=2, `W_DATA`=3.

Eligibility:
- `elig0 = m0_req & (m0_addr[31]==S_NO)`; `elig1` likewise for master 1.

FSM states: `IDLE`, `BUSY`, `RDATA`.
- `IDLE`:
  - If neither master is eligible, stay in `IDLE`.
  - Otherwise pick the winner:
    - Only one eligible: that master wins.
    - Both eligible: the master ≠ `last_grant` wins.
  - Register `owner`, `s_addr`, `s_cmd`, `s_wdata` from the winner, set `s_req`=1, go to `BUSY`.
- `BUSY`:
  - `s_req` stays 1 and the slave fields stay frozen.
  - When `s_ack`=1:
    - `m<owner>_ack`=1 in the same cycle.
    - `last_grant` ← `owner`.
    - `s_req` ← 0.
    - Next state is `RDATA` if `s_cmd`=0, otherwise `IDLE`.
- `RDATA`: lasts exactly one cycle (the slave's rdata cycle), then go to `IDLE`.

Ack routing:
- `mX_ack = (state==BUSY) & s_ack & (owner==X)`.
- A non-owner never sees an ack.
- `s_ack` arriving in `IDLE` or `RDATA` is ignored.

Stat, combinational, for each master X:
- Reset asserted: `NO_REQ`.
- `state==RDATA` and `owner==X`: `W_DATA`.
- `state==BUSY` and `owner==X`: `W_ACK`.
- `eligX`: `WAIT`.
- Otherwise: `NO_REQ`.

Protocol violation: if the owner drops `req` during `BUSY`, the transaction still completes. No abort.

## Timing
- Reset values: state `IDLE`, `s_req`=0, `s_addr`=0, `s_cmd`=0, `s_wdata`=0, `owner`=0, `last_grant`=1 (so master 0 wins the first tie). Acks 0, stat `NO_REQ`.
- Reset mid-transaction: the next cycle is `IDLE` with `s_req`=0. The pending ack is lost and the master must retry.
- Request to `s_req` latency: 1 cycle. A request seen in `IDLE` at edge N gives `s_req`=1 after edge N.
- Ack: zero-cycle pass-through from `s_ack` to `mX_ack`.
- Throughput: a write takes 2 cycles minimum (`IDLE`→`BUSY`), a read 3 cycles (`IDLE`→`BUSY`→`RDATA`).
- Back-to-back, both masters requesting continuously: grants alternate 0,1,0,1.
- A master that re-requests right after its own ack loses to the other master if that one is eligible.
- Request and ack in the same cycle is impossible: `s_req` is registered.

## Structure
- Shared package `crossbar_pkg`: `NO_REQ`/`WAIT`/`W_ACK`/`W_DATA`, `CMD_READ`=0, `CMD_WRITE`=1, FSM state encoding.
- Sub-module `rr_arb2`: inputs `elig0`, `elig1`, `last_grant`; outputs `gnt_valid`, `gnt_idx`. Purely combinational.
- Top level holds the FSM, the slave-field registers and the stat/ack logic.

## Test plan
- Reset, then idle:
  - `rst`=1 for 2 cycles → all outputs at reset values, stat0 = stat1 = `NO_REQ`.
  - No requests → `s_req` stays 0.
- Single write, `S_NO`=0:
  - m0 sends req, addr=0x0000_0010, cmd=1, wdata=0xA5A5_A5A5 → next cycle `s_req`=1 with those fields, stat0=`W_ACK`.
  - `s_ack` 2 cycles later → `m0_ack`=1 in that cycle, `s_req`=0 next cycle, stat0=`NO_REQ` once m0 drops req.
- Read:
  - m1 sends read, addr=0x0000_0004 → stat1 sequence `WAIT`, `W_ACK`…, then `W_DATA` for exactly one cycle after ack, then back to `IDLE`.
- Contention:
  - m0 and m1 both request addr bit31=0, continuously, with the slave acking every `BUSY` cycle → grant order 0,1,0,1.
  - The non-owner reads `WAIT` throughout.
- Address filter:
  - Instance with `S_NO`=1; m0 requests addr=0x0000_0000 → never granted, stat0=`NO_REQ`, `s_req`=0.
- Reset mid-`BUSY`:
  - Assert `rst` while `s_req`=1 → `s_req`=0 next cycle, no ack issued, `last_grant`=1.
